// File: rtl/spi_master_reader.sv
// SPI mode-0 read master: shifts out an address, then clocks in a data word.
// Chip select frames each transaction, and a guaranteed CS-high gap separates frames.
module spi_master_reader #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              spi_clk,
    output logic              spi_cs,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int                 FRAME_BITS = ADDR_W + DATA_W;
    localparam int                 CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(FRAME_BITS - 1);
    localparam logic [7:0]         DIV_RELOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t            state;
    logic [7:0]        div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              miso_meta;
    logic              miso_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= spi_miso;
            miso_sync <= miso_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            addr_sr  <= '0;
            rx_sr    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            spi_clk  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            // NOTE: default-low here makes done a single-cycle pulse without extra state.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_sr  <= addr;
                        spi_mosi <= addr[ADDR_W-1];
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= DIV_RELOAD;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_cnt == '0) begin
                        spi_clk <= 1'b1;
                        div_cnt <= DIV_RELOAD;
                        state   <= XFER;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                XFER: begin
                    // First clk of the high half: the synchronizer now holds the bit
                    // the slave launched on the previous falling edge.
                    if (spi_clk && div_cnt == DIV_RELOAD)
                        rx_sr <= {rx_sr[DATA_W-2:0], miso_sync};
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_RELOAD;
                        if (spi_clk) begin
                            spi_clk  <= 1'b0;
                            spi_mosi <= addr_sr[ADDR_W-2];
                            addr_sr  <= {addr_sr[ADDR_W-2:0], 1'b0};
                        end else if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                        end else begin
                            spi_clk <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_cnt == '0) begin
                        spi_cs  <= 1'b1;
                        done    <= 1'b1;
                        rdata   <= rx_sr;
                        div_cnt <= DIV_RELOAD;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (div_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
